// File: rtl/bcd_time_counter_if.sv
`default_nettype none
// ============================================================================
// bcd_time_counter_if : control inputs and BCD time outputs of bcd_time_counter
// Optional: HOUR12_EN adds the pm flag.        Revision: 1.0
// ============================================================================
interface bcd_time_counter_if;
  logic       EN_work;
  logic       inc_min;
  logic       inc_hour;
  logic [3:0] sec_low;
  logic [3:0] sec_high;
  logic [3:0] min_low;
  logic [3:0] min_high;
  logic [3:0] hour_low;
  logic [3:0] hour_high;
  logic       sec_pulse;
  logic       hour_carry;
`ifdef HOUR12_EN
  logic       pm;
`endif

  modport master (
`ifdef HOUR12_EN
    input  pm,
`endif
    output EN_work, inc_min, inc_hour,
    input  sec_low, sec_high, min_low, min_high, hour_low, hour_high,
    input  sec_pulse, hour_carry
  );

  modport slave (
`ifdef HOUR12_EN
    output pm,
`endif
    input  EN_work, inc_min, inc_hour,
    output sec_low, sec_high, min_low, min_high, hour_low, hour_high,
    output sec_pulse, hour_carry
  );
endinterface
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// ============================================================================
// bcd_time_counter : 1 Hz divider plus hh:mm:ss BCD time-of-day with set mode
// Optional: HOUR12_EN selects 12-hour coding with a pm flag.   Revision: 1.0
// ============================================================================
module bcd_time_counter #(
  parameter int CLK_DIV = 1000
) (
  input  wire logic          CLK,
  input  wire logic          RST_n,
  bcd_time_counter_if.slave  bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
`ifdef HOUR12_EN
  localparam logic [3:0] C_HH_RST = 4'd1;
  localparam logic [3:0] C_HL_RST = 4'd2;
`else
  localparam logic [3:0] C_HH_RST = 4'd0;
  localparam logic [3:0] C_HL_RST = 4'd0;
`endif

  // Returns {wrap, tens, units} for a 00..59 BCD pair.
  function automatic logic [8:0] base60_step(input logic [3:0] hi, input logic [3:0] lo);
    if (lo >= 4'd9) begin
      if (hi >= 4'd5) return {1'b1, 4'd0, 4'd0};
      return {1'b0, hi + 4'd1, 4'd0};
    end
    return {1'b0, hi, lo + 4'd1};
  endfunction

  function automatic logic [7:0] hour_step(input logic [3:0] hh, input logic [3:0] hl);
`ifdef HOUR12_EN
    if (hh >= 4'd1 && hl >= 4'd2) return {4'd0, 4'd1};
    if (hh >= 4'd1 && hl == 4'd1) return {4'd1, 4'd2};
    if (hl >= 4'd9)               return {4'd1, 4'd0};
    return {hh, hl + 4'd1};
`else
    if (hh >= 4'd2 && hl >= 4'd3) return {4'd0, 4'd0};
    if (hl >= 4'd9)               return {hh + 4'd1, 4'd0};
    return {hh, hl + 4'd1};
`endif
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       sl_q, sl_d, sh_q, sh_d;
  logic [3:0]       ml_q, ml_d, mh_q, mh_d;
  logic [3:0]       hl_q, hl_d, hh_q, hh_d;
  logic             pulse_q, pulse_d;
  logic             carry_q, carry_d;
  logic             min_prev_q, hour_prev_q;
`ifdef HOUR12_EN
  logic             pm_q, pm_d;
  logic             w_pm_flip;
`endif

  logic       w_min_edge, w_hour_edge, w_tick;
  logic [8:0] w_sec_nxt, w_min_nxt;
  logic [7:0] w_hour_nxt;

  assign w_min_edge  = bus.inc_min  & ~min_prev_q;
  assign w_hour_edge = bus.inc_hour & ~hour_prev_q;
  assign w_tick      = (div_q >= C_DIV_LAST);
  assign w_sec_nxt   = base60_step(sh_q, sl_q);
  assign w_min_nxt   = base60_step(mh_q, ml_q);
  assign w_hour_nxt  = hour_step(hh_q, hl_q);
`ifdef HOUR12_EN
  // Every 11 -> 12 transition crosses the AM/PM boundary.
  assign w_pm_flip   = (hh_q == 4'd1) && (hl_q == 4'd1);
`endif

  always_comb begin
    div_d   = div_q;
    sl_d    = sl_q;
    sh_d    = sh_q;
    ml_d    = ml_q;
    mh_d    = mh_q;
    hl_d    = hl_q;
    hh_d    = hh_q;
    pulse_d = 1'b0;
    carry_d = 1'b0;
`ifdef HOUR12_EN
    pm_d    = pm_q;
`endif
    if (bus.EN_work) begin
      // Set mode takes priority even on a divider wrap edge.
      div_d = '0;
      sl_d  = 4'd0;
      sh_d  = 4'd0;
      if (w_min_edge) begin
        mh_d = w_min_nxt[7:4];
        ml_d = w_min_nxt[3:0];
      end
      if (w_hour_edge) begin
        hh_d = w_hour_nxt[7:4];
        hl_d = w_hour_nxt[3:0];
`ifdef HOUR12_EN
        if (w_pm_flip) pm_d = ~pm_q;
`endif
      end
    end else if (w_tick) begin
      div_d   = '0;
      pulse_d = 1'b1;
      sh_d    = w_sec_nxt[7:4];
      sl_d    = w_sec_nxt[3:0];
      if (w_sec_nxt[8]) begin
        mh_d = w_min_nxt[7:4];
        ml_d = w_min_nxt[3:0];
        if (w_min_nxt[8]) begin
          carry_d = 1'b1;
          hh_d    = w_hour_nxt[7:4];
          hl_d    = w_hour_nxt[3:0];
`ifdef HOUR12_EN
          if (w_pm_flip) pm_d = ~pm_q;
`endif
        end
      end
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      div_q       <= '0;
      sl_q        <= 4'd0;
      sh_q        <= 4'd0;
      ml_q        <= 4'd0;
      mh_q        <= 4'd0;
      hl_q        <= C_HL_RST;
      hh_q        <= C_HH_RST;
      pulse_q     <= 1'b0;
      carry_q     <= 1'b0;
      min_prev_q  <= 1'b0;
      hour_prev_q <= 1'b0;
`ifdef HOUR12_EN
      pm_q        <= 1'b0;
`endif
    end else begin
      div_q       <= div_d;
      sl_q        <= sl_d;
      sh_q        <= sh_d;
      ml_q        <= ml_d;
      mh_q        <= mh_d;
      hl_q        <= hl_d;
      hh_q        <= hh_d;
      pulse_q     <= pulse_d;
      carry_q     <= carry_d;
      min_prev_q  <= bus.inc_min;
      hour_prev_q <= bus.inc_hour;
`ifdef HOUR12_EN
      pm_q        <= pm_d;
`endif
    end
  end

  assign bus.sec_low    = sl_q;
  assign bus.sec_high   = sh_q;
  assign bus.min_low    = ml_q;
  assign bus.min_high   = mh_q;
  assign bus.hour_low   = hl_q;
  assign bus.hour_high  = hh_q;
  assign bus.sec_pulse  = pulse_q;
  assign bus.hour_carry = carry_q;
`ifdef HOUR12_EN
  assign bus.pm         = pm_q;
`endif

  a_digits_in_range : assert property (@(posedge CLK) disable iff (!RST_n)
    (sl_q <= 4'd9) && (sh_q <= 4'd5) && (ml_q <= 4'd9) && (mh_q <= 4'd5) &&
`ifdef HOUR12_EN
    ((hh_q == 4'd0 && hl_q >= 4'd1 && hl_q <= 4'd9) || (hh_q == 4'd1 && hl_q <= 4'd2))
`else
    (hl_q <= 4'd9) && ((hh_q <= 4'd1) || (hh_q == 4'd2 && hl_q <= 4'd3))
`endif
  );

endmodule
`default_nettype wire

// File: tb/tb_bcd_time_counter.sv
`default_nettype none
// ============================================================================
// tb_bcd_time_counter : vector table, corner sequences and randomized run of
// bcd_time_counter against a seconds-of-day reference model. Revision: 1.0
// ============================================================================
module tb_bcd_time_counter;
  localparam int CLK_DIV = 4;

  logic CLK;
  logic RST_n;
  bcd_time_counter_if bus ();

  bcd_time_counter #(.CLK_DIV(CLK_DIV)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  // Reference model: time as seconds since midnight plus a divider count.
  int t_sec;
  int div_cnt;
  bit prev_min, prev_hour;
  bit exp_pulse, exp_carry;

  typedef struct {
    logic        en;
    logic        im;
    logic        ih;
    int          cyc;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(logic en, logic im, logic ih, int cyc, logic [23:0] exp);
    vec_t v;
    v.en = en; v.im = im; v.ih = ih; v.cyc = cyc; v.exp = exp;
    return v;
  endfunction

  task automatic model_reset();
    t_sec = 0; div_cnt = 0; prev_min = 0; prev_hour = 0;
    exp_pulse = 0; exp_carry = 0;
  endtask

  task automatic model_step(bit en, bit im, bit ih);
    exp_pulse = 0;
    exp_carry = 0;
    if (en) begin
      int h, m;
      h = t_sec / 3600;
      m = (t_sec / 60) % 60;
      if (im && !prev_min)  m = (m + 1) % 60;
      if (ih && !prev_hour) h = (h + 1) % 24;
      t_sec = h * 3600 + m * 60;
      div_cnt = 0;
    end else if (div_cnt == CLK_DIV - 1) begin
      div_cnt = 0;
      t_sec = (t_sec + 1) % 86400;
      exp_pulse = 1;
      exp_carry = (t_sec % 3600 == 0);
    end else begin
      div_cnt++;
    end
    prev_min = im;
    prev_hour = ih;
  endtask

  function automatic logic [23:0] model_digits();
    int h, m, s, hd;
    h = t_sec / 3600;
    m = (t_sec / 60) % 60;
    s = t_sec % 60;
`ifdef HOUR12_EN
    hd = (h % 12 == 0) ? 12 : h % 12;
`else
    hd = h;
`endif
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] dut_digits();
    return {bus.hour_high, bus.hour_low, bus.min_high, bus.min_low, bus.sec_high, bus.sec_low};
  endfunction

  task automatic check_model(string name);
    bit bad;
    bad = (dut_digits() !== model_digits()) || (bus.sec_pulse !== exp_pulse) ||
          (bus.hour_carry !== exp_carry);
`ifdef HOUR12_EN
    bad = bad || (bus.pm !== (t_sec >= 43200));
`endif
    n_tests++;
    if (bad) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL %s @%0t: got %h pulse=%0b carry=%0b, expected %h pulse=%0b carry=%0b",
                 name, $time, dut_digits(), bus.sec_pulse, bus.hour_carry,
                 model_digits(), exp_pulse, exp_carry);
    end
  endtask

  task automatic check_val(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic cycle(bit en, bit im, bit ih);
    bus.EN_work = en; bus.inc_min = im; bus.inc_hour = ih;
    @(posedge CLK);
    model_step(en, im, ih);
    @(negedge CLK);
    if (bus.sec_pulse === 1'b1) pulse_cnt++;
    check_model("cycle");
  endtask

  task automatic press(bit m, bit h);
    cycle(1, m, h);
    cycle(1, 0, 0);
  endtask

  // Asserts reset in the middle of a cycle so its asynchronous effect is visible.
  task automatic apply_reset();
    #2;
    RST_n = 1'b0;
    bus.EN_work = 0; bus.inc_min = 0; bus.inc_hour = 0;
    #1;
    model_reset();
    check_model("async_reset");
    @(negedge CLK);
    RST_n = 1'b1;
    pulse_cnt = 0;
  endtask

  initial begin
    int first;
    bit en_r;
    RST_n = 1'b0;
    bus.EN_work = 0; bus.inc_min = 0; bus.inc_hour = 0;
    model_reset();
    @(negedge CLK);
    check_model("reset_state");
    RST_n = 1'b1;

    vecs[0] = mk(0, 0, 0, 8,  24'h000002);
    vecs[1] = mk(1, 1, 0, 10, 24'h000100);
    vecs[2] = mk(1, 0, 1, 3,  24'h010100);
    vecs[3] = mk(1, 0, 0, 1,  24'h010100);
    vecs[4] = mk(1, 1, 1, 1,  24'h020200);
    vecs[5] = mk(1, 0, 0, 1,  24'h020200);
    vecs[6] = mk(0, 0, 0, 12, 24'h020203);
    vecs[7] = mk(0, 1, 1, 4,  24'h020204);
    vecs[8] = mk(1, 1, 1, 2,  24'h020200);

    for (int i = 0; i < 9; i++) begin
      repeat (vecs[i].cyc) cycle(vecs[i].en, vecs[i].im, vecs[i].ih);
      check_val($sformatf("vec%0d", i), 32'(dut_digits()), 32'(vecs[i].exp));
      if (i == 0) check_val("vec0_pulses", pulse_cnt, 2);
    end

    // One minute of counting from reset.
    apply_reset();
    repeat (240) cycle(0, 0, 0);
    check_val("minute_digits", 32'(dut_digits()), 32'h000100);
    check_val("minute_pulses", pulse_cnt, 60);
    check_val("minute_pulse_now", 32'(bus.sec_pulse), 1);

    // Minute wrap in set mode, simultaneous steps, then day rollover by counting.
    apply_reset();
    cycle(1, 0, 0);
    repeat (23) press(0, 1);
    repeat (59) press(1, 0);
    check_val("set_2359", 32'(dut_digits()), 32'h235900);
    press(1, 0);
    check_val("min_wrap_no_carry", 32'(dut_digits()), 32'h230000);
    repeat (59) press(1, 0);
    press(1, 1);
    check_val("both_steps_2359", 32'(dut_digits()), 32'h000000);
    repeat (23) press(0, 1);
    repeat (59) press(1, 0);
    repeat (59 * CLK_DIV) cycle(0, 0, 0);
    check_val("pre_rollover", 32'(dut_digits()), 32'h235959);
    repeat (CLK_DIV) cycle(0, 0, 0);
    check_val("rollover_digits", 32'(dut_digits()), 32'h000000);
    check_val("rollover_flags", {30'd0, bus.sec_pulse, bus.hour_carry}, 32'h3);

    // Reset in mid-second, then the first pulse after leaving set mode.
    apply_reset();
    cycle(1, 0, 0);
    repeat (5) press(0, 1);
    repeat (30) press(1, 0);
    repeat (17 * CLK_DIV + 2) cycle(0, 0, 0);
    check_val("at_053017", 32'(dut_digits()), 32'h053017);
    apply_reset();
    check_val("after_reset_digits", 32'(dut_digits()), 32'h000000);
    repeat (3) cycle(1, 0, 0);
    first = 0;
    for (int i = 1; i <= 3 * CLK_DIV; i++) begin
      cycle(0, 0, 0);
      if (bus.sec_pulse === 1'b1) begin
        first = i;
        break;
      end
    end
    check_val("first_pulse_latency", first, CLK_DIV);

    // Entering set mode on the wrap edge suppresses the increment.
    apply_reset();
    repeat (CLK_DIV - 1) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check_val("set_wins_digits", 32'(dut_digits()), 32'h000000);
    check_val("set_wins_pulse", 32'(bus.sec_pulse), 0);
    repeat (CLK_DIV) cycle(0, 0, 0);
    check_val("restart_second", 32'(dut_digits()), 32'h000001);

    // Randomized mix of run and set periods with button noise.
    apply_reset();
    en_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) en_r = ~en_r;
      cycle(en_r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
